wave_analyzer: RTL

- Consumer-side counterpart of the function-generator sine/wave sources.
- Takes a stream of signed samples with a valid strobe and detects rising zero crossings, using hysteresis against noise.
- For each full cycle it measures the period in samples, the maximum, the minimum and the half peak-to-peak amplitude.
- Results go to the display/verification logic, which checks generator output against expected frequency and amplitude.

---
 rtl/wave_analyzer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wave_analyzer.sv
// wave_analyzer: measures a signed sample stream cycle by cycle.
// A rising zero crossing is detected with hysteresis. A sample counts as HIGH
// when it is >= +HYST and as LOW when it is <= -HYST. For every complete
// cycle, from one rising crossing up to (but excluding) the next, the block
// reports the period in samples, the running max/min and the half
// peak-to-peak amplitude.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_sample qualified signed input sample
//   clr               synchronous soft clear (same effect as rst)
//   period            samples in the last complete cycle
//   max_val/min_val   signed extremes of the last complete cycle
//   amp               (max_val - min_val) >> 1, unsigned
//   out_valid         one-cycle pulse when the result outputs update
//   locked            at least one cycle measured since reset/clear/overflow
//   overflow          sticky; a cycle ran past the period counter range
module wave_analyzer #(
  parameter int N    = 16,
  parameter int CW   = 16,
  parameter int HYST = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [N-1:0] in_sample,
  input  logic                clr,
  output logic [CW-1:0]       period,
  output logic signed [N-1:0] max_val,
  output logic signed [N-1:0] min_val,
  output logic [N-1:0]        amp,
  output logic                out_valid,
  output logic                locked,
  output logic                overflow
);

  typedef enum logic [1:0] {S_INIT, S_ARM, S_RUN_HI, S_RUN_LO} state_e;

  localparam logic signed [N-1:0] HYST_P = N'(HYST);
  localparam logic signed [N-1:0] HYST_N = -HYST_P;

  // Input stage: a sample presented at edge k is evaluated by the FSM at edge
  // k+1. Results are therefore visible one cycle after the completing sample
  // is accepted.
  logic                vld_q;
  logic signed [N-1:0] smp_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q <= 1'b0;
      smp_q <= '0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) smp_q <= in_sample;
    end
  end

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic signed [N-1:0] run_max_q, run_min_q;
  logic [CW-1:0]       period_q;
  logic signed [N-1:0] max_q, min_q;
  logic [N-1:0]        amp_q;
  logic                out_valid_q, locked_q, overflow_q;

  logic                is_low, is_high, cnt_full;
  logic signed [N-1:0] run_max_d, run_min_d;
  logic [N:0]          span_d;
  logic [N-1:0]        amp_d;
  logic [CW-1:0]       cnt_d;

  assign is_low    = (smp_q <= HYST_N);
  assign is_high   = (smp_q >= HYST_P);
  assign cnt_full  = &cnt_q;
  assign cnt_d     = cnt_q + CW'(1);
  assign run_max_d = (smp_q > run_max_q) ? smp_q : run_max_q;
  assign run_min_d = (smp_q < run_min_q) ? smp_q : run_min_q;
  // One extra bit for the span so that max-min never wraps. The result is
  // non-negative, so the half span always fits N unsigned bits.
  assign span_d    = {run_max_q[N-1], run_max_q} - {run_min_q[N-1], run_min_q};
  assign amp_d     = N'(span_d >> 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_min_q   <= '0;
      period_q    <= '0;
      max_q       <= '0;
      min_q       <= '0;
      amp_q       <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (vld_q) begin
        case (state_q)
          S_INIT: if (is_low) state_q <= S_ARM;
          S_ARM: begin
            if (is_high) begin
              state_q   <= S_RUN_HI;
              cnt_q     <= CW'(1);
              run_max_q <= smp_q;
              run_min_q <= smp_q;
            end
          end
          S_RUN_HI, S_RUN_LO: begin
            if (state_q == S_RUN_LO && is_high) begin
              // Cycle complete; the crossing sample opens the next cycle.
              period_q    <= cnt_q;
              max_q       <= run_max_q;
              min_q       <= run_min_q;
              amp_q       <= amp_d;
              out_valid_q <= 1'b1;
              locked_q    <= 1'b1;
              state_q     <= S_RUN_HI;
              cnt_q       <= CW'(1);
              run_max_q   <= smp_q;
              run_min_q   <= smp_q;
            end else if (cnt_full) begin
              // The cycle is too long to count; drop it and re-acquire.
              overflow_q <= 1'b1;
              locked_q   <= 1'b0;
              state_q    <= S_INIT;
              cnt_q      <= '0;
            end else begin
              cnt_q     <= cnt_d;
              run_max_q <= run_max_d;
              run_min_q <= run_min_d;
              if (is_low) state_q <= S_RUN_LO;
            end
          end
          default: state_q <= S_INIT;
        endcase
      end
    end
  end

  assign period    = period_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign amp       = amp_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign overflow  = overflow_q;

endmodule
